mips_mem_responder: RTL and testbench

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_responder.sv | 98 +++++++++
 tb/tb_mips_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - word-addressed memory responder for a MIPS MEM stage
// Single-outstanding request/response handshake with fixed extra latency and range check.
module mips_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           data_q;
  logic                  err_q;
  logic                  accept;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rdata_n;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready && !rst;
  assign in_range  = (req_addr >> DEPTH_LOG2) == 32'd0;
  assign idx       = req_addr[DEPTH_LOG2-1:0];
  // Stores and out-of-range requests always answer with zero data.
  assign rdata_n   = (in_range && !req_we) ? mem[idx] : 32'd0;

  // Storage is deliberately outside the reset domain so its contents survive rst.
  always_ff @(posedge clk1) begin
    if (accept && req_we && in_range) begin
      mem[idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      data_q    <= 32'd0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wait_cnt <= 4'd0;
            data_q   <= rdata_n;
            err_q    <= !in_range;
            if (WAIT_CYCLES == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_n;
              rsp_err   <= !in_range;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= data_q;
            rsp_err   <= err_q;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed bench for mips_mem_responder
// Two instances: WAIT_CYCLES=2 for most scenarios, WAIT_CYCLES=0 for back-to-back throughput.
module tb_mips_mem_responder;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  mips_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut2 (
    .clk1(clk1), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mips_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk1(clk1), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Full transaction on dut2 starting from IDLE; lat=99 flags a missing response.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_we = 1'b1; req_addr = 32'h0000_0007; req_wdata = 32'hbad0_bad0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!rsp_valid) lat = 99;
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_valid0 = 1'b1; rsp_ready = 1'b1; rsp_ready0 = 1'b1;
    req_we = 1'b1; req_addr = 32'd3; req_wdata = 32'h1111_1111;
    tick();
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    total++; if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
      bad++; $display("FAIL reset_w0 got ready=%b valid=%b exp ready=1 valid=0", req_ready0, rsp_valid0);
    end
    req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b0; rsp_ready0 = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'd0, 32'h2801_000a, rd, er, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL store_latency got=%0d exp=3", lat); end
    total++; if (er !== 1'b0 || rd !== 32'd0) begin
      bad++; $display("FAIL store_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd);
    end
    txn(1'b0, 32'd0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h2801_000a) begin bad++; $display("FAIL load_after_store got=%h exp=2801000a", rd); end
    total++; if (lat != 3 || er !== 1'b0) begin bad++; $display("FAIL load_lat_err got lat=%0d err=%b exp 3/0", lat, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    txn(1'b1, 32'd5, 32'h0022_2000, rd, er, lat);
    req_we = 1'b0; req_addr = 32'd5; req_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0022_2000 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d got valid=%b rdata=%h err=%b ready=%b exp 1/00222000/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_complete got valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h0000_0400, 32'hffff_ffff, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0 || lat != 3) begin
      bad++; $display("FAIL oor_store got err=%b rdata=%h lat=%0d exp 1/0/3", er, rd, lat);
    end
    txn(1'b1, 32'h0001_0000, 32'h0000_0055, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_upper_store got err=%b exp=1", er); end
    txn(1'b0, 32'd0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h2801_000a) begin bad++; $display("FAIL oor_unchanged got=%h exp=2801000a", rd); end
    txn(1'b0, 32'h0000_0400, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL oor_load got err=%b rdata=%h exp 1/0", er, rd);
    end
    txn(1'b1, 32'h0000_03ff, 32'h0000_a5a5, rd, er, lat);
    txn(1'b0, 32'h0000_03ff, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0000_a5a5 || er !== 1'b0) begin
      bad++; $display("FAIL top_word got rdata=%h err=%b exp 0000a5a5/0", rd, er);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] rd; logic er; int lat; int n; logic seen;
    txn(1'b1, 32'd7, 32'h0000_0077, rd, er, lat);
    req_we = 1'b0; req_addr = 32'd0; req_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'hdead_beef;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    req_valid = 1'b0;
    total++; if (rsp_rdata !== 32'h2801_000a) begin bad++; $display("FAIL ign_rsp got=%h exp=2801000a", rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= rsp_valid | ~req_ready;
      tick();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ign_extra_rsp got=%b exp=0", seen); end
    txn(1'b0, 32'd7, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0000_0077) begin bad++; $display("FAIL ign_addr7 got=%h exp=00000077", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int n; logic seen;
    req_we = 1'b0; req_addr = 32'd0; req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_in_wait got ready=%b exp=0", req_ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_after_rst got ready=%b valid=%b exp 1/0", req_ready, rsp_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin seen |= rsp_valid; tick(); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got=%b exp=0", seen); end
    rsp_ready = 1'b0;
    txn(1'b0, 32'd0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h2801_000a) begin bad++; $display("FAIL mid_storage got=%h exp=2801000a", rd); end
    // Reset while a store response is pending: the write must stay committed.
    req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'h1357_9bdf; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    rst = 1'b1; rsp_ready = 1'b1;
    tick();
    rst = 1'b0; rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL resp_rst got valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
    txn(1'b0, 32'd9, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h1357_9bdf) begin bad++; $display("FAIL committed_store got=%h exp=13579bdf", rd); end
  endtask

  task automatic test_back_to_back();
    logic        ops_we   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ops_addr [6] = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd2, 32'd3};
    logic [31:0] ops_wd   [6] = '{32'd10, 32'd20, 32'd25, 32'd0, 32'd0, 32'd0};
    logic [31:0] ops_exp  [6] = '{32'd0, 32'd0, 32'd0, 32'd10, 32'd20, 32'd25};
    int n;
    n = 0;
    req_we = ops_we[0]; req_addr = ops_addr[0]; req_wdata = ops_wd[0];
    req_valid0 = 1'b1; rsp_ready0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (rsp_valid0 !== ((k % 2) == 0) || req_ready0 !== ((k % 2) == 1)) begin
        bad++;
        $display("FAIL b2b_rate_%0d got valid=%b ready=%b exp valid=%0d", k, rsp_valid0, req_ready0, (k % 2) == 0);
      end
      if (rsp_valid0 === 1'b1 && n < 6) begin
        total++;
        if (rsp_rdata0 !== ops_exp[n] || rsp_err0 !== 1'b0) begin
          bad++; $display("FAIL b2b_data_%0d got rdata=%0d err=%b exp %0d/0", n, rsp_rdata0, rsp_err0, ops_exp[n]);
        end
        n++;
        if (n < 6) begin
          req_we = ops_we[n]; req_addr = ops_addr[n]; req_wdata = ops_wd[n];
        end else begin
          req_valid0 = 1'b0;
        end
      end
    end
    req_valid0 = 1'b0; rsp_ready0 = 1'b0;
    total++; if (n != 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", n); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b0; rsp_ready0 = 1'b0;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    test_reset();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
